// File: rtl/des3_cbc_sequencer_pkg.sv
// Shared definitions for the des3 CBC/ECB block sequencer: FSM state
// encoding, block width and timeout defaults.
package des3_cbc_sequencer_pkg;

    localparam int BLK_W = 64;

    localparam int DES3_TIMEOUT_CYC_DEFAULT = 1023;

    localparam int TMO_MIN_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_LO = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_HOLD    = 2'd3
    } seq_state_e;

    // Width of the WAIT_HI timeout counter: wide enough for the limit,
    // never narrower than ten bits.
    function automatic int tmo_width(input int cyc);
        int w;
        w = $clog2(cyc + 1);
        return (w < TMO_MIN_W) ? TMO_MIN_W : w;
    endfunction

endpackage

// File: rtl/des3_cbc_sequencer_xor_chain.sv
// Chaining datapath for the sequencer: holds the CBC chain register and
// builds the core input / result words for ECB, CBC encrypt and CBC decrypt.
module des3_cbc_xor_chain
    import des3_cbc_sequencer_pkg::*;
(
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             mode_cbc,
    input  logic             mode_decrypt,
    input  logic             use_iv,
    input  logic [BLK_W-1:0] iv,
    input  logic [BLK_W-1:0] blk_new,
    input  logic [BLK_W-1:0] blk_held,
    input  logic [BLK_W-1:0] core_dout,
    input  logic             load,
    input  logic             update,
    output logic [BLK_W-1:0] din_next,
    output logic [BLK_W-1:0] dout_next
);

    logic [BLK_W-1:0] chain_q;
    logic [BLK_W-1:0] chain_cur;

    // Chain reloads the IV on the first block of a message and otherwise
    // advances only when a core result is actually taken.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            chain_q <= '0;
        end else if (load && use_iv) begin
            chain_q <= iv;
        end else if (update && mode_cbc) begin
            chain_q <= mode_decrypt ? blk_held : core_dout;
        end
    end

    // Encrypt chaining XORs on the way into the core, decrypt chaining on
    // the way out; the IV bypasses the register for a message's first block.
    always_comb begin
        chain_cur = use_iv ? iv : chain_q;
        din_next  = (mode_cbc && !mode_decrypt) ? (blk_new ^ chain_cur) : blk_new;
        dout_next = (mode_cbc && mode_decrypt) ? (core_dout ^ chain_q) : core_dout;
    end

endmodule

// File: rtl/des3_cbc_sequencer.sv
// Block sequencer in front of an external des3 core: accepts one 64-bit
// block at a time, handshakes with the core and presents the result
// downstream, with optional CBC chaining and a core timeout.
module des3_cbc_sequencer
    import des3_cbc_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYC = DES3_TIMEOUT_CYC_DEFAULT
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cfg_cbc,
    input  logic             cfg_decrypt,
    input  logic [BLK_W-1:0] cfg_iv,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic             out_last,
    output logic             core_start,
    output logic             core_decrypt,
    output logic [BLK_W-1:0] core_din,
    input  logic [BLK_W-1:0] core_dout,
    input  logic             core_valid,
    output logic             err_timeout,
    output logic [31:0]      blk_count
);

    localparam int TMO_W = tmo_width(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    seq_state_e       state;
    logic             first_q;
    logic             cbc_q;
    logic             last_q;
    logic [BLK_W-1:0] blk_q;
    logic [TMO_W-1:0] tmo_cnt;

    logic             accepting;
    logic             first_accept;
    logic             mode_cbc;
    logic             mode_dec;
    logic             take_result;
    logic [BLK_W-1:0] din_next;
    logic [BLK_W-1:0] dout_next;

    // Mode used by the chain datapath: fresh cfg_* on a message's first
    // block, the latched copy for every later block.
    always_comb begin
        accepting    = (state == ST_IDLE) && in_valid;
        first_accept = accepting && first_q;
        mode_cbc     = first_accept ? cfg_cbc : cbc_q;
        mode_dec     = first_accept ? cfg_decrypt : core_decrypt;
        take_result  = (state == ST_WAIT_HI) && core_valid;
    end

    des3_cbc_xor_chain u_chain (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .mode_cbc     (mode_cbc),
        .mode_decrypt (mode_dec),
        .use_iv       (first_accept),
        .iv           (cfg_iv),
        .blk_new      (in_data),
        .blk_held     (blk_q),
        .core_dout    (core_dout),
        .load         (accepting),
        .update       (take_result),
        .din_next     (din_next),
        .dout_next    (dout_next)
    );

    // Sequencer FSM with registered handshake and core-control outputs.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state        <= ST_IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            core_start   <= 1'b0;
            core_decrypt <= 1'b0;
            core_din     <= '0;
            out_data     <= '0;
            out_last     <= 1'b0;
            err_timeout  <= 1'b0;
            blk_count    <= '0;
            first_q      <= 1'b1;
            cbc_q        <= 1'b0;
            last_q       <= 1'b0;
            blk_q        <= '0;
            tmo_cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        blk_q    <= in_data;
                        last_q   <= in_last;
                        core_din <= din_next;
                        if (first_q) begin
                            cbc_q        <= cfg_cbc;
                            core_decrypt <= cfg_decrypt;
                        end
                        first_q  <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    if (!core_valid) begin
                        core_start <= 1'b1;
                        tmo_cnt    <= '0;
                        state      <= ST_WAIT_HI;
                    end
                end
                ST_WAIT_HI: begin
                    if (core_valid) begin
                        out_data   <= dout_next;
                        out_last   <= last_q;
                        out_valid  <= 1'b1;
                        core_start <= 1'b0;
                        state      <= ST_HOLD;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_timeout <= 1'b1;
                        core_start  <= 1'b0;
                        in_ready    <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        blk_count <= blk_count + 32'd1;
                        in_ready  <= 1'b1;
                        if (out_last) begin
                            first_q <= 1'b1;
                        end
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
